apb_sram_arbiter: RTL and testbench
===================================

# apb_sram_arbiter

Two-port APB master that shares one `apb_sram_beta` slave between two on-chip requesters. Each requester issues single word read/write transactions over a hold-until-done handshake. The block arbitrates round-robin, sequences the APB SETUP/ACCESS phases and returns read data and completion status per port. A wait-state watchdog aborts a hung transfer. It sits between the requesters and the SRAM, in place of the bench master model.

## Interface
Parameters:
- `addr_bits`, default 10: SRAM word-address width; byte address is `addr_bits+2` bits.
- `timeout`, default 16: maximum ACCESS cycles allowed with `pready`=0 before abort; legal range 2..255.

Ports:
- `clk`, in, 1: single clock. All logic is rising-edge.
- `rstn`, in, 1: reset, asynchronous assert, active-low.
- `req0` / `req1`, in, 1: transaction request. Held high with fields stable until the matching done pulse.
- `we0` / `we1`, in, 1: 1 = write, 0 = read.
- `addr0` / `addr1`, in, `addr_bits+2`: byte address. Bits [1:0] are ignored.
- `wdata0` / `wdata1`, in, 32: write data.
- `done0` / `done1`, out, 1: one-cycle completion pulse.
- `rdata0` / `rdata1`, out, 32: read data. Valid while the matching done is high; held until that port's next completion.
- `err0` / `err1`, out, 1: high with done when the transfer hit the watchdog.
- `psel`, `penable`, `pwrite`, out, 1 each: APB controls.
- `paddr`, out, `addr_bits+2`: APB address. Bits [1:0] are always 0.
- `pwdata`, out, 32: APB write data.
- `pready`, in, 1: APB slave ready.
- `prdata`, in, 32: APB read data.

## Operation
- Four states: IDLE, SETUP, ACCESS, DONE. One transfer is in flight at a time.
- IDLE: if any req is high, latch the winner's index, we, addr and wdata, then go to SETUP. Otherwise stay in IDLE.
- Round-robin arbitration:
  - `last` register holds the index of the last port served.
  - With both reqs high, grant `~last`. With one req high, grant that port.
  - `last` updates on grant.
  - Reset value of `last` is 1, so port 0 wins the first tie.
- SETUP: `psel`=1, `penable`=0, address/control/data driven from the latched values. Always lasts exactly 1 cycle, then ACCESS.
- ACCESS: `psel`=1, `penable`=1, same values as SETUP.
  - `pready`=1: capture `prdata` into the winner's rdata register on reads (rdata is unchanged on writes), clear the error flag, go to DONE.
  - `pready`=0: increment the wait counter.
  - Counter reaches `timeout`: abort, set the error flag, zero the winner's rdata, go to DONE.
- DONE: `psel`=`penable`=0. `done<winner>`=1 and `err<winner>`=flag for this one cycle. Both reqs are ignored. Next state is IDLE unconditionally.
- Requester rule: drop req, or present the next transaction, by the edge that ends DONE. The earliest next grant is sampled in the following IDLE.
- The wait counter clears on every entry to SETUP. Its width is clog2(`timeout`+1).
- Reset mid-transfer: all state returns to IDLE immediately. No done pulse is issued and the in-flight transfer is lost.

## Timing
- Reset values: all outputs 0; `last`=1; state IDLE; wait counter 0.
- All outputs are registered. No combinational path from any input to any output.
- Zero-wait transfer: req sampled high at edge k → SETUP in cycle k+1 → ACCESS in cycle k+2 (pready=1) → DONE in cycle k+3 → IDLE in cycle k+4.
  - Minimum 4 cycles per transfer.
  - Each wait state adds 1 cycle.
- Timeout: with `pready` stuck at 0, ACCESS lasts exactly `timeout` cycles before DONE.
- `paddr`, `pwrite` and `pwdata` are stable from SETUP through the last ACCESS cycle. They keep their values in DONE and IDLE (they are not cleared).
- `pwdata` is don't-care to the slave on reads but is still driven from the latch.

## Structure
- Shared package `apb_sram_pkg`:
  - State enum `apb_st_t` (IDLE, SETUP, ACCESS, DONE).
  - Port-index constants `PORT0`/`PORT1`.
  - `APB_DATA_W`=32.
- Sub-module `apb_rr_arb2`: two-way round-robin picker.
  - Inputs: req[1:0], last, enable.
  - Outputs: grant index, grant_valid.
  - `last` is updated inside the sub-module on grant.
- Top level holds the FSM, transaction latches, wait counter and per-port rdata/done/err registers.

## Test plan
- Reset: hold `rstn`=0 → all outputs 0. Then single write on port 0 to addr 0x010 with data 0xDEADBEEF, slave zero-wait → psel/penable pattern 10, 11, 00; paddr=0x010; done0 in cycle k+3; err0=0.
- Read-back: port 1 reads 0x010 → rdata1=0xDEADBEEF with done1; rdata0 unchanged.
- Contention: req0 and req1 both held for 4 transactions from reset → grant order 0,1,0,1. No done overlap; exactly 4 cycles between done pulses.
- Wait states: slave inserts 3 wait cycles → ACCESS lasts 4 cycles, done 3 cycles later than zero-wait; addr 0x013 drives paddr=0x010.
- Watchdog: `timeout`=16 with `pready` held 0 → ACCESS lasts 16 cycles; done0=1, err0=1, rdata0=0. The next transfer succeeds with err0=0.
- Reset mid-ACCESS: drop `rstn` during a wait state → psel/penable go to 0 asynchronously; no done. After release, a tie grants port 0.

Source files
------------

// File: rtl/apb_sram_arbiter_pkg.sv
// rtl/apb_sram_arbiter_pkg.sv - shared types and constants for the two-port APB SRAM arbiter
package apb_sram_pkg;

  localparam int APB_DATA_W = 32;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } apb_st_t;

  // Winner of a two-way round-robin pick; a tie goes to the port not served last.
  function automatic logic rr_pick(input logic [1:0] req, input logic last);
    logic pick;
    pick = PORT0;
    if (req == 2'b11) begin
      pick = ~last;
    end else if (req[1]) begin
      pick = PORT1;
    end
    return pick;
  endfunction

endpackage

// File: rtl/apb_sram_arbiter_if.sv
// rtl/apb_sram_arbiter_if.sv - requester handshakes and APB bus of the two-port SRAM arbiter
interface apb_sram_arbiter_if #(
  parameter int addr_bits = 10
);
  import apb_sram_pkg::*;

  logic                  req0;
  logic                  req1;
  logic                  we0;
  logic                  we1;
  logic [addr_bits+1:0]  addr0;
  logic [addr_bits+1:0]  addr1;
  logic [APB_DATA_W-1:0] wdata0;
  logic [APB_DATA_W-1:0] wdata1;
  logic                  done0;
  logic                  done1;
  logic [APB_DATA_W-1:0] rdata0;
  logic [APB_DATA_W-1:0] rdata1;
  logic                  err0;
  logic                  err1;

  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [addr_bits+1:0]  paddr;
  logic [APB_DATA_W-1:0] pwdata;
  logic                  pready;
  logic [APB_DATA_W-1:0] prdata;

  modport master (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, pready, prdata,
    output done0, done1, rdata0, rdata1, err0, err1,
    output psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, pready, prdata,
    input  done0, done1, rdata0, rdata1, err0, err1,
    input  psel, penable, pwrite, paddr, pwdata
  );

endinterface

// File: rtl/apb_sram_arbiter_rr_arb2.sv
// rtl/apb_sram_arbiter_rr_arb2.sv - two-way round-robin picker that owns the last-served register
module apb_rr_arb2
  import apb_sram_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] req,
  input  logic       enable,
  output logic       grant,
  output logic       grant_valid
);

  logic last;

  always_comb begin
    grant       = rr_pick(req, last);
    grant_valid = enable & (|req);
  end

  // Reset to port 1 so the first tie after reset goes to port 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last <= PORT1;
    end else if (grant_valid) begin
      last <= grant;
    end
  end

endmodule

// File: rtl/apb_sram_arbiter.sv
// rtl/apb_sram_arbiter.sv - shares one APB SRAM slave between two requesters with a wait-state watchdog
module apb_sram_arbiter
  import apb_sram_pkg::*;
#(
  parameter int addr_bits = 10,
  parameter int timeout   = 16
) (
  input logic                clk,
  input logic                rstn,
  apb_sram_arbiter_if.master bus
);

  localparam int CW = $clog2(timeout + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(timeout - 1);
  localparam logic [addr_bits+1:0] WORD_MASK = ~((addr_bits + 2)'(3));

  apb_st_t               state;
  logic                  cur;
  logic [CW-1:0]         wait_cnt;
  logic                  psel_q;
  logic                  penable_q;
  logic                  pwrite_q;
  logic [addr_bits+1:0]  paddr_q;
  logic [APB_DATA_W-1:0] pwdata_q;
  logic [APB_DATA_W-1:0] rdata0_q;
  logic [APB_DATA_W-1:0] rdata1_q;
  logic                  done0_q;
  logic                  done1_q;
  logic                  err0_q;
  logic                  err1_q;

  logic                  gnt;
  logic                  gnt_valid;
  logic                  sel_we;
  logic [addr_bits+1:0]  sel_addr;
  logic [APB_DATA_W-1:0] sel_wdata;

  apb_rr_arb2 u_arb (
    .clk         (clk),
    .rstn        (rstn),
    .req         ({bus.req1, bus.req0}),
    .enable      (state == IDLE),
    .grant       (gnt),
    .grant_valid (gnt_valid)
  );

  always_comb begin
    sel_we    = bus.we0;
    sel_addr  = bus.addr0;
    sel_wdata = bus.wdata0;
    if (gnt == PORT1) begin
      sel_we    = bus.we1;
      sel_addr  = bus.addr1;
      sel_wdata = bus.wdata1;
    end
  end

  // paddr/pwrite/pwdata double as the transaction latch and are left as-is after the transfer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cur       <= PORT0;
      wait_cnt  <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            cur       <= gnt;
            pwrite_q  <= sel_we;
            paddr_q   <= sel_addr & WORD_MASK;
            pwdata_q  <= sel_wdata;
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            wait_cnt  <= '0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state     <= ACCESS;
        end
        ACCESS: begin
          if (bus.pready) begin
            if (!pwrite_q) begin
              if (cur == PORT1) rdata1_q <= bus.prdata;
              else              rdata0_q <= bus.prdata;
            end
            done0_q   <= (cur == PORT0);
            done1_q   <= (cur == PORT1);
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            state     <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            // Watchdog: this is the timeout-th cycle spent waiting.
            if (wait_cnt == WAIT_LAST) begin
              if (cur == PORT1) rdata1_q <= '0;
              else              rdata0_q <= '0;
              done0_q   <= (cur == PORT0);
              done1_q   <= (cur == PORT1);
              err0_q    <= (cur == PORT0);
              err1_q    <= (cur == PORT1);
              psel_q    <= 1'b0;
              penable_q <= 1'b0;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          done0_q <= 1'b0;
          done1_q <= 1'b0;
          err0_q  <= 1'b0;
          err1_q  <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.psel    = psel_q;
  assign bus.penable = penable_q;
  assign bus.pwrite  = pwrite_q;
  assign bus.paddr   = paddr_q;
  assign bus.pwdata  = pwdata_q;
  assign bus.rdata0  = rdata0_q;
  assign bus.rdata1  = rdata1_q;
  assign bus.done0   = done0_q;
  assign bus.done1   = done1_q;
  assign bus.err0    = err0_q;
  assign bus.err1    = err1_q;

endmodule

// File: tb/tb_apb_sram_arbiter.sv
// tb/tb_apb_sram_arbiter.sv - directed table-driven bench for apb_sram_arbiter
module tb_apb_sram_arbiter;

  localparam int AB = 10;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  apb_sram_arbiter_if #(.addr_bits(AB)) bus ();

  apb_sram_arbiter #(.addr_bits(AB), .timeout(TO)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // Slave: word memory with a programmable number of wait states per access.
  logic [31:0] mem [0:1023] = '{default: 32'h0};
  int waits = 0;
  int acc_cnt = 0;

  always_comb begin
    bus.pready = (acc_cnt >= waits);
    bus.prdata = mem[bus.paddr[11:2]];
  end

  always @(posedge clk) begin
    if (bus.psel && bus.penable && !bus.pready) acc_cnt <= acc_cnt + 1;
    else                                        acc_cnt <= 0;
    if (bus.psel && bus.penable && bus.pready && bus.pwrite)
      mem[bus.paddr[11:2]] <= bus.pwdata;
  end

  typedef struct {
    logic        port;
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    int          waits;
    int          lat;
    int          acc;
    logic        err;
    logic [31:0] rdata;
    logic [11:0] paddr;
  } vec_t;

  vec_t tbl [11];
  logic [31:0] hold [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_reqs();
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.we0 = 1'b0;  bus.we1 = 1'b0;
    bus.addr0 = '0;  bus.addr1 = '0;
    bus.wdata0 = '0; bus.wdata1 = '0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    idle_reqs();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic run_txn(input vec_t v, output int lat, output int acc,
                         output logic [31:0] rd, output logic er,
                         output logic [11:0] pa, output logic ok);
    @(negedge clk);
    waits = v.waits;
    lat = 0; acc = 0; rd = '0; er = 1'b0; pa = '0; ok = 1'b0;
    if (v.port) begin
      bus.req1 = 1'b1; bus.we1 = v.we; bus.addr1 = v.addr; bus.wdata1 = v.wdata;
    end else begin
      bus.req0 = 1'b1; bus.we0 = v.we; bus.addr0 = v.addr; bus.wdata0 = v.wdata;
    end
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (bus.psel && bus.penable) begin
        acc++;
        pa = bus.paddr;
      end
      if (v.port ? bus.done1 : bus.done0) begin
        lat = c;
        rd  = v.port ? bus.rdata1 : bus.rdata0;
        er  = v.port ? bus.err1 : bus.err0;
        ok  = 1'b1;
        break;
      end
    end
    idle_reqs();
  endtask

  initial begin
    int   lat, acc, n, t_last, first_port;
    logic [31:0] rd;
    logic [11:0] pa;
    logic er, ok, saw_done;
    int   order [4];
    int   when [4];

    //           port  we    addr    wdata          wt   lat acc err  rdata          paddr
    tbl[0]  = '{1'b0, 1'b1, 12'h010, 32'hDEADBEEF, 0,   3,  1,  1'b0, 32'h00000000, 12'h010};
    tbl[1]  = '{1'b1, 1'b0, 12'h010, 32'h0,        0,   3,  1,  1'b0, 32'hDEADBEEF, 12'h010};
    tbl[2]  = '{1'b0, 1'b1, 12'h013, 32'h12345678, 3,   6,  4,  1'b0, 32'h00000000, 12'h010};
    tbl[3]  = '{1'b1, 1'b0, 12'h010, 32'h0,        1,   4,  2,  1'b0, 32'h12345678, 12'h010};
    tbl[4]  = '{1'b0, 1'b0, 12'h010, 32'h0,        0,   3,  1,  1'b0, 32'h12345678, 12'h010};
    tbl[5]  = '{1'b0, 1'b0, 12'h020, 32'h0,        255, 18, 16, 1'b1, 32'h00000000, 12'h020};
    tbl[6]  = '{1'b0, 1'b0, 12'h013, 32'h0,        2,   5,  3,  1'b0, 32'h12345678, 12'h010};
    tbl[7]  = '{1'b1, 1'b1, 12'hFFC, 32'hA5A50F0F, 0,   3,  1,  1'b0, 32'h12345678, 12'hFFC};
    tbl[8]  = '{1'b0, 1'b0, 12'hFFF, 32'h0,        0,   3,  1,  1'b0, 32'hA5A50F0F, 12'hFFC};
    tbl[9]  = '{1'b1, 1'b1, 12'h000, 32'h11111111, 255, 18, 16, 1'b1, 32'h00000000, 12'h000};
    tbl[10] = '{1'b1, 1'b0, 12'hFFC, 32'h0,        0,   3,  1,  1'b0, 32'hA5A50F0F, 12'hFFC};

    idle_reqs();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_psel",    {31'h0, bus.psel},    32'h0);
    check("rst_penable", {31'h0, bus.penable}, 32'h0);
    check("rst_done",    {30'h0, bus.done1, bus.done0}, 32'h0);
    check("rst_err",     {30'h0, bus.err1, bus.err0},   32'h0);
    check("rst_rdata0",  bus.rdata0, 32'h0);
    check("rst_rdata1",  bus.rdata1, 32'h0);
    check("rst_paddr",   {20'h0, bus.paddr}, 32'h0);
    rstn = 1'b1;

    hold[0] = '0; hold[1] = '0;
    for (int i = 0; i < 11; i++) begin
      run_txn(tbl[i], lat, acc, rd, er, pa, ok);
      check($sformatf("v%0d_done_seen", i), {31'h0, ok}, 32'h1);
      check($sformatf("v%0d_latency", i), lat, tbl[i].lat);
      check($sformatf("v%0d_access_cycles", i), acc, tbl[i].acc);
      check($sformatf("v%0d_paddr", i), {20'h0, pa}, {20'h0, tbl[i].paddr});
      check($sformatf("v%0d_err", i), {31'h0, er}, {31'h0, tbl[i].err});
      check($sformatf("v%0d_rdata", i), rd, tbl[i].rdata);
      hold[tbl[i].port] = tbl[i].rdata;
      check($sformatf("v%0d_other_rdata", i),
            tbl[i].port ? bus.rdata0 : bus.rdata1, hold[~tbl[i].port]);
    end

    // Contention from reset: both ports held for four transfers.
    do_reset();
    @(negedge clk);
    waits = 0;
    bus.req0 = 1'b1; bus.addr0 = 12'h010;
    bus.req1 = 1'b1; bus.addr1 = 12'hFFC;
    n = 0;
    for (int c = 1; c <= 60 && n < 4; c++) begin
      @(negedge clk);
      if (bus.done0 && bus.done1) check("contend_overlap", 32'h1, 32'h0);
      if (bus.done0 || bus.done1) begin
        order[n] = bus.done1 ? 1 : 0;
        when[n] = c;
        n++;
      end
    end
    idle_reqs();
    check("contend_count", n, 4);
    if (n == 4) begin
      for (int j = 0; j < 4; j++) check($sformatf("contend_order%0d", j), order[j], j % 2);
      for (int j = 1; j < 4; j++) check($sformatf("contend_gap%0d", j), when[j] - when[j-1], 4);
      check("contend_first_latency", when[0], 3);
    end

    // Reset during a wait state.
    @(negedge clk);
    waits = 255;
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 12'h010;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.psel && bus.penable) begin ok = 1'b1; break; end
    end
    check("midrst_reached_access", {31'h0, ok}, 32'h1);
    repeat (2) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("midrst_psel_async",    {31'h0, bus.psel},    32'h0);
    check("midrst_penable_async", {31'h0, bus.penable}, 32'h0);
    check("midrst_rdata0",        bus.rdata0, 32'h0);
    idle_reqs();
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done0 || bus.done1) saw_done = 1'b1;
    end
    rstn = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (bus.done0 || bus.done1) saw_done = 1'b1;
    end
    check("midrst_no_done", {31'h0, saw_done}, 32'h0);

    waits = 0;
    bus.req0 = 1'b1; bus.addr0 = 12'h010;
    bus.req1 = 1'b1; bus.addr1 = 12'hFFC;
    first_port = -1;
    t_last = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.done0 || bus.done1) begin
        first_port = bus.done1 ? 1 : 0;
        t_last = c;
        break;
      end
    end
    idle_reqs();
    check("post_rst_tie_port", first_port, 0);
    check("post_rst_tie_latency", t_last, 3);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
